// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Drain stage for an 8-bit synchronous FIFO. Whenever transmission is enabled and
// the FIFO holds data, one byte is popped and sent on a UART-style line:
// start bit, 8 data bits LSB first, optional even parity bit, one stop bit.
//
// Optional feature: define FIFO_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11-bit frames instead of 10).
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
// Ports:
//   i_clk         system clock, all logic on the rising edge
//   i_rst         synchronous active-high reset
//   i_tx_en       allow fetching a new byte (looked at only while idle)
//   i_fifo_empty  FIFO empty flag
//   i_fifo_data   FIFO read data, valid the cycle after o_fifo_rd is sampled
//   o_fifo_rd     FIFO read strobe, one cycle per byte
//   o_tx          serial line, idles high
//   o_busy        high whenever a byte is being fetched or sent
//   o_tx_done     one-cycle pulse during the last cycle of the stop bit
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_en,
    input  logic       i_fifo_empty,
    input  logic [7:0] i_fifo_data,
    output logic       o_fifo_rd,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_tx_done
);

    localparam logic [15:0] BIT_LOAD = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        START,
        DATA,
`ifdef FIFO_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_bitIdx;
    logic [7:0]  r_shift;
    logic        r_fifoRd;
    logic        r_tx;
    logic        r_busy;
    logic        r_txDone;

    state_t      w_state;
    logic [15:0] w_cnt;
    logic [2:0]  w_bitIdx;
    logic [7:0]  w_shift;
    logic        w_fifoRd;
    logic        w_tx;
    logic        w_busy;
    logic        w_txDone;

`ifdef FIFO_TX_PARITY_EN
    // Parity is taken from the byte as captured, since the shift register
    // is consumed while the data bits go out.
    logic r_parity;
    logic w_parity;
`endif

    // Next-state logic. Every bit state reloads the bit timer on entry and
    // leaves when the timer reads zero, giving CLKS_PER_BIT cycles per bit.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_bitIdx = r_bitIdx;
        w_shift  = r_shift;
`ifdef FIFO_TX_PARITY_EN
        w_parity = r_parity;
`endif
        case (r_state)
            IDLE: begin
                if (i_tx_en && !i_fifo_empty) begin
                    w_state = READ;
                end
            end
            READ: begin
                w_state = LOAD;
            end
            LOAD: begin
                w_shift  = i_fifo_data;
                w_cnt    = BIT_LOAD;
                w_state  = START;
`ifdef FIFO_TX_PARITY_EN
                w_parity = ^i_fifo_data;
`endif
            end
            START: begin
                if (r_cnt == 16'd0) begin
                    w_state  = DATA;
                    w_cnt    = BIT_LOAD;
                    w_bitIdx = 3'd0;
                end else begin
                    w_cnt = r_cnt - 16'd1;
                end
            end
            DATA: begin
                if (r_cnt == 16'd0) begin
                    w_shift  = {1'b0, r_shift[7:1]};
                    w_cnt    = BIT_LOAD;
                    w_bitIdx = r_bitIdx + 3'd1;
                    if (r_bitIdx == 3'd7) begin
`ifdef FIFO_TX_PARITY_EN
                        w_state = PARITY;
`else
                        w_state = STOP;
`endif
                    end
                end else begin
                    w_cnt = r_cnt - 16'd1;
                end
            end
`ifdef FIFO_TX_PARITY_EN
            PARITY: begin
                if (r_cnt == 16'd0) begin
                    w_state = STOP;
                    w_cnt   = BIT_LOAD;
                end else begin
                    w_cnt = r_cnt - 16'd1;
                end
            end
`endif
            STOP: begin
                if (r_cnt == 16'd0) begin
                    w_state = IDLE;
                end else begin
                    w_cnt = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so they can be registered
    // and still line up with the state they belong to.
    always_comb begin
        w_fifoRd = (w_state == READ);
        w_busy   = (w_state != IDLE);
        w_txDone = (w_state == STOP) && (w_cnt == 16'd0);
        case (w_state)
            START:   w_tx = 1'b0;
            DATA:    w_tx = w_shift[0];
`ifdef FIFO_TX_PARITY_EN
            PARITY:  w_tx = w_parity;
`endif
            default: w_tx = 1'b1;
        endcase
    end

    // State and output registers; reset forces the line high on the next edge
    // and drops any byte already popped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_cnt    <= 16'd0;
            r_bitIdx <= 3'd0;
            r_shift  <= 8'd0;
            r_fifoRd <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_txDone <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_bitIdx <= w_bitIdx;
            r_shift  <= w_shift;
            r_fifoRd <= w_fifoRd;
            r_tx     <= w_tx;
            r_busy   <= w_busy;
            r_txDone <= w_txDone;
`ifdef FIFO_TX_PARITY_EN
            r_parity <= w_parity;
`endif
        end
    end

    assign o_fifo_rd = r_fifoRd;
    assign o_tx      = r_tx;
    assign o_busy    = r_busy;
    assign o_tx_done = r_txDone;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
// Bench for fifo_uart_tx with CLKS_PER_BIT=4. A queue stands in for the FIFO,
// a frame-level model predicts fifo_rd/tx/busy/tx_done every cycle, and
// directed scenarios add hand-computed expectations (latency, line pattern,
// gap length, FIFO occupancy, parity bit when FIFO_TX_PARITY_EN is defined).
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       txEn = 1'b0;
    logic       fifoEmpty = 1'b1;
    logic [7:0] fifoData = 8'h00;
    logic       dutRd;
    logic       dutTx;
    logic       dutBusy;
    logic       dutDone;

    logic [7:0] fifoQ[$];
    logic       popPending = 1'b0;
    logic [3:0] sched[$];
    logic [3:0] expOut = 4'b0100;

    int checks = 0;
    int failures = 0;
    int rdPulses = 0;
    int donePulses = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_tx_en      (txEn),
        .i_fifo_empty (fifoEmpty),
        .i_fifo_data  (fifoData),
        .o_fifo_rd    (dutRd),
        .o_tx         (dutTx),
        .o_busy       (dutBusy),
        .o_tx_done    (dutDone)
    );

    always #5 clk = ~clk;

    // Expected per-cycle outputs {rd, tx, busy, done} for one whole frame:
    // fetch cycle, data-valid cycle, the serial bits, then one idle cycle.
    task automatic buildFrame(input logic [7:0] b);
        logic lineBits[$];
        lineBits.push_back(1'b0);
        for (int i = 0; i < 8; i++) lineBits.push_back(b[i]);
`ifdef FIFO_TX_PARITY_EN
        lineBits.push_back(^b);
`endif
        lineBits.push_back(1'b1);
        sched.push_back(4'b1110);
        sched.push_back(4'b0110);
        for (int k = 0; k < lineBits.size(); k++) begin
            for (int c = 0; c < CPB; c++) begin
                sched.push_back({1'b0, lineBits[k], 1'b1,
                                 (k == lineBits.size() - 1) && (c == CPB - 1)});
            end
        end
        sched.push_back(4'b0100);
    endtask

    // Model step on each rising edge, using the values the DUT sees there.
    always @(posedge clk) begin
        popPending = dutRd;
        if (rst) begin
            sched.delete();
            expOut = 4'b0100;
        end else begin
            if (sched.size() == 0 && txEn && !fifoEmpty) buildFrame(fifoQ[0]);
            if (sched.size() > 0) expOut = sched.pop_front();
            else expOut = 4'b0100;
        end
    end

    // FIFO stand-in: the pop requested at a rising edge lands before the
    // next rising edge, so data is valid the cycle after fifo_rd.
    always @(negedge clk) begin
        if (popPending && fifoQ.size() > 0) fifoData = fifoQ.pop_front();
        popPending = 1'b0;
        fifoEmpty = (fifoQ.size() == 0);
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        checks++;
        if ({dutRd, dutTx, dutBusy, dutDone} !== expOut) begin
            failures++;
            $display("[TB] FAIL cycleModel t=%0t rd/tx/busy/done actual=%b required=%b",
                     $time, {dutRd, dutTx, dutBusy, dutDone}, expOut);
        end
        if (dutRd === 1'b1) rdPulses++;
        if (dutDone === 1'b1) donePulses++;
    end

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic rstV, input logic enV);
        @(negedge clk);
        #1;
        rst  = rstV;
        txEn = enV;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) step();
    endtask

    // Counts cycles until the line is seen low; ends on that sample.
    task automatic waitFall(input string name, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (dutTx !== 1'b0 && cyc < 300);
        if (dutTx !== 1'b0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout actual=no_start required=start", name);
        end
    endtask

`ifdef FIFO_TX_PARITY_EN
    task automatic checkParityFrame(input logic [7:0] b, input int expParity);
        int cyc;
        applyStimulus(1'b0, 1'b1);
        fifoQ.push_back(b);
        waitFall("parityStart", cyc);
        for (int i = 0; i < FRAME_CYC; i++) begin
            if (i == 9 * CPB + 1) checkOutput("parityBit", dutTx, expParity);
            if (i == FRAME_CYC - 1) checkOutput("parityFrameDone", dutDone, 1);
            if (i != FRAME_CYC - 1) step();
        end
        waitCycles(4);
    endtask
`endif

    initial begin
        int cyc;
        int highs;
        int rdBase;
        int doneBase;
        int sizeBefore;
        logic lineA5[NBITS];
`ifdef FIFO_TX_PARITY_EN
        lineA5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
        lineA5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif

        // Reset hold with a byte waiting and transmission enabled.
        applyStimulus(1'b1, 1'b1);
        fifoQ.push_back(8'hA5);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("resetTx", dutTx, 1);
            checkOutput("resetRd", dutRd, 0);
            checkOutput("resetBusy", dutBusy, 0);
        end

        // Single byte 0xA5.
        rdBase = rdPulses;
        doneBase = donePulses;
        applyStimulus(1'b0, 1'b1);
        waitFall("a5Start", cyc);
        checkOutput("startLatency", cyc, 3);
        for (int i = 0; i < FRAME_CYC; i++) begin
            checkOutput("a5Line", dutTx, int'(lineA5[i / CPB]));
            if (i != FRAME_CYC - 1) step();
        end
        checkOutput("a5DoneLastStop", dutDone, 1);
        waitCycles(2);
        checkOutput("a5RdPulses", rdPulses - rdBase, 1);
        checkOutput("a5DonePulses", donePulses - doneBase, 1);
        checkOutput("a5BusyAfter", dutBusy, 0);

        // Back-to-back 0x00 then 0xFF.
        rdBase = rdPulses;
        applyStimulus(1'b0, 1'b1);
        fifoQ.push_back(8'h00);
        fifoQ.push_back(8'hFF);
        waitFall("b2bStart", cyc);
        cyc = 0;
        while (dutTx !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        highs = 0;
        while (dutTx === 1'b1 && highs < 100) begin
            step();
            highs++;
        end
        checkOutput("b2bGapHigh", highs, CPB + 3);
        waitCycles(FRAME_CYC + 3);
        checkOutput("b2bRdPulses", rdPulses - rdBase, 2);
        checkOutput("b2bFifoCount", fifoQ.size(), 0);
        checkOutput("b2bFifoEmpty", fifoEmpty, 1);
        checkOutput("b2bBusyAfter", dutBusy, 0);

        // tx_en dropped during DATA of 0x3C with two bytes still queued.
        rdBase = rdPulses;
        doneBase = donePulses;
        applyStimulus(1'b0, 1'b1);
        fifoQ.push_back(8'h3C);
        fifoQ.push_back(8'h11);
        fifoQ.push_back(8'h22);
        waitFall("enDropStart", cyc);
        waitCycles(3 * CPB);
        applyStimulus(1'b0, 1'b0);
        waitCycles(FRAME_CYC + 10);
        checkOutput("enDropRd", rdPulses - rdBase, 1);
        checkOutput("enDropDone", donePulses - doneBase, 1);
        checkOutput("enDropFifoCount", fifoQ.size(), 2);
        checkOutput("enDropBusy", dutBusy, 0);
        waitCycles(20);
        checkOutput("enDropHoldRd", rdPulses - rdBase, 1);
        applyStimulus(1'b0, 1'b1);
        waitCycles(2 * (FRAME_CYC + 3) + 10);
        checkOutput("enResumeRd", rdPulses - rdBase, 3);
        checkOutput("enResumeFifoCount", fifoQ.size(), 0);
        checkOutput("enResumeBusy", dutBusy, 0);

        // Reset during data bit 4 of 0x5A, with 0xC3 queued behind it.
        rdBase = rdPulses;
        applyStimulus(1'b0, 1'b1);
        fifoQ.push_back(8'h5A);
        fifoQ.push_back(8'hC3);
        waitFall("midResetStart", cyc);
        waitCycles(5 * CPB + 1);
        sizeBefore = fifoQ.size();
        checkOutput("midResetFifoBefore", sizeBefore, 1);
        applyStimulus(1'b1, 1'b1);
        step();
        checkOutput("midResetTx", dutTx, 1);
        checkOutput("midResetBusy", dutBusy, 0);
        checkOutput("midResetRd", dutRd, 0);
        checkOutput("midResetFifoAfter", fifoQ.size(), sizeBefore);
        applyStimulus(1'b0, 1'b1);
        waitFall("restartStart", cyc);
        checkOutput("restartLatency", cyc, 3);
        waitCycles(FRAME_CYC + 3);
        checkOutput("restartRd", rdPulses - rdBase, 2);
        checkOutput("restartFifoCount", fifoQ.size(), 0);
        checkOutput("restartBusy", dutBusy, 0);

`ifdef FIFO_TX_PARITY_EN
        checkParityFrame(8'h07, 1);
        checkParityFrame(8'h03, 0);
`endif

        waitCycles(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
